adc_conv_sched: RTL and testbench
=================================

# adc_conv_sched

Multi-channel conversion scheduler for the SAR ADC macro. Up to NCH requesters post conversion requests. A round-robin arbiter picks one. The block then drives the analog input-mux select and comparator-source select, waits a programmable settling time, pulses the SAR `start`, and waits for `done` under a timeout. It returns the 8-bit result, tagged with the channel, to the requester. It sits between the digital requesters (bus wrapper, sequencer) and the ADC macro's `start`/`done`/`data`/`cmp_sel`/`rst` pins.

## Interface
Parameters:
- NCH, 4: number of requesters/channels (2..8).
- TMO, 64: conversion timeout in clk cycles, measured from the `adc_start` pulse.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  scheduler enable; 0 means no new grants, and an in-flight conversion still completes.
- req  input  NCH  per-channel request pulses; each pulse sets that channel's pending bit.
- cfg_cmp_sel  input  NCH  per-channel comparator source (0 internal, 1 external).
- settle_cycles  input  8  mux settling delay in cycles; 0 means no delay.
- mux_sel  output  $clog2(NCH)  analog input-mux select, held from grant through the response.
- adc_cmp_sel  output  1  drives the ADC `cmp_sel` pin.
- adc_start  output  1  one-cycle conversion start pulse.
- adc_rst  output  1  one-cycle SAR reset pulse, issued on timeout.
- adc_done  input  1  SAR done.
- adc_data  input  8  SAR result.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_ch  output  $clog2(NCH)  channel of the response.
- rsp_data  output  8  result; 0 when rsp_err=1.
- rsp_err  output  1  conversion timed out.
- pending  output  NCH  pending request bits.
- busy  output  1  FSM not in IDLE.

## Operation
Pending bits:
- `pend[i]` is set when `req[i]`=1 and cleared in RESP for the served channel.
- If a set and a clear hit the same bit in the same cycle, the set wins and the request is re-queued.

FSM states are IDLE, SETTLE, START, CONV, RESP.
- **IDLE:**
  - If en=1 and pend≠0, grant the first pending channel at or after `rr_ptr`, searching upward with wrap.
  - Register `mux_sel`=ch and `adc_cmp_sel`=cfg_cmp_sel[ch].
  - Load `cnt`=settle_cycles and go to SETTLE.
  - Update `rr_ptr`=ch+1 mod NCH.
- **SETTLE:**
  - cnt==0: go to START.
  - Otherwise decrement `cnt`.
  - `adc_done` is ignored in this state.
- **START:**
  - `adc_start`=1 for this cycle.
  - Clear the timer and go to CONV.
- **CONV:**
  - Done is detected on a rising edge of `adc_done` (registered previous value). A level left high by a stale conversion is never accepted.
  - On a rising edge: capture `adc_data`, set err=0, go to RESP.
  - Else if timer==TMO-1: set err=1 and data=0, pulse `adc_rst`, go to RESP.
  - Otherwise increment the timer.
- **RESP:**
  - Assert `rsp_valid` with `rsp_ch`/`rsp_data`/`rsp_err`.
  - Clear pend[ch] and go to IDLE.

Other rules:
- `mux_sel` and `adc_cmp_sel` change only on a grant.
- `cfg_cmp_sel` and `settle_cycles` are sampled only at grant or load time.
- Changes to `en` mid-conversion have no effect until IDLE.

## Timing
Reset values:
- All outputs are 0 on reset: `pending`=0, `busy`=0, `mux_sel`=0, `adc_cmp_sel`=0, `rsp_*`=0, `adc_start`=0, `adc_rst`=0.
- `rr_ptr`=0 and the FSM is in IDLE.

Latency:
- `req` at edge N sets pend at N+1.
- The grant (SETTLE entry) happens at N+2.
- `adc_start` is high in cycle N+3+settle_cycles.
- `rsp_valid` is asserted one cycle after the CONV cycle that sees the done rising edge.
- The minimum per-conversion IDLE→IDLE time is 4 cycles plus the settle and conversion time.

Reset mid-operation:
- rst=1 in any state returns to IDLE and clears pend in the same edge.
- No `rsp_valid` is emitted for an aborted conversion.

Back-to-back and response timing:
- Back-to-back grants have one IDLE cycle between RESP and the next SETTLE.
- `rsp_*` are valid only while rsp_valid=1; there is no backpressure.

## Structure
- Package `adc_sched_pkg`:
  - FSM state enum `sched_state_t`.
  - Default constants `ADC_W`=8 and `TMO_DEF`=64.
- Sub-module `rr_arbiter`, parameterised on NCH:
  - Inputs: pend, rr_ptr.
  - Outputs: any, grant index.
  - Purely combinational priority search with wrap.

## Test plan
- **Single request:** settle_cycles=3, req[2] pulse, done rises 10 cycles after start with data=0xA5. Required: mux_sel=2, adc_start exactly 4 cycles after entering SETTLE, rsp_valid with ch=2, data=0xA5, err=0, pending=0.
- **Round-robin fairness:** req on all 4 channels in the same cycle, rr_ptr=0. Required: responses in channel order 0,1,2,3. A re-request of ch0 during its own RESP is served after ch3.
- **Timeout:** TMO=64, done never rises. Required: adc_rst pulse 64 cycles after adc_start, rsp_err=1, rsp_data=0, FSM back in IDLE.
- **Stale done:** adc_done held high across START. Required: no response until done falls and rises again.
- **Reset mid-CONV:** rst=1 in CONV. Required: next cycle has busy=0, pending=0, and no rsp_valid.
- **Enable and config sampling:** en=0 with pending requests, and cfg_cmp_sel[1]=1. Required: no grant while en=0. After en=1, ch1 is served with adc_cmp_sel=1, and settle_cycles=0 gives adc_start on the cycle after the grant.

Source files
------------

// File: rtl/adc_conv_sched_pkg.sv
// Shared types and defaults for the SAR ADC conversion scheduler.
package adc_sched_pkg;

    localparam int ADC_W   = 8;
    localparam int TMO_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_CONV,
        ST_RESP
    } sched_state_t;

endpackage

// File: rtl/adc_conv_sched_if.sv
// Requester, configuration, ADC macro and response signals of the conversion scheduler.
interface adc_conv_sched_if
    import adc_sched_pkg::*;
#(
    parameter int NCH = 4
);
    localparam int CHW = $clog2(NCH);

    logic             en;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   cfg_cmp_sel;
    logic [7:0]       settle_cycles;
    logic [CHW-1:0]   mux_sel;
    logic             adc_cmp_sel;
    logic             adc_start;
    logic             adc_rst;
    logic             adc_done;
    logic [ADC_W-1:0] adc_data;
    logic             rsp_valid;
    logic [CHW-1:0]   rsp_ch;
    logic [ADC_W-1:0] rsp_data;
    logic             rsp_err;
    logic [NCH-1:0]   pending;
    logic             busy;

    // master is the scheduler itself; slave is the requesters plus the ADC macro
    modport master (
        input  en, req, cfg_cmp_sel, settle_cycles, adc_done, adc_data,
        output mux_sel, adc_cmp_sel, adc_start, adc_rst,
               rsp_valid, rsp_ch, rsp_data, rsp_err, pending, busy
    );

    modport slave (
        output en, req, cfg_cmp_sel, settle_cycles, adc_done, adc_data,
        input  mux_sel, adc_cmp_sel, adc_start, adc_rst,
               rsp_valid, rsp_ch, rsp_data, rsp_err, pending, busy
    );

endinterface

// File: rtl/adc_conv_sched_rr_arbiter.sv
// Round-robin pick: first set bit of pend at or above rr_ptr, wrapping past NCH-1.
module rr_arbiter #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         pend,
    input  logic [$clog2(NCH)-1:0] rr_ptr,
    output logic                   any,
    output logic [$clog2(NCH)-1:0] idx
);
    localparam int CHW = $clog2(NCH);

    // Scan from farthest to nearest so the nearest pending channel is written last.
    always_comb begin
        int j;
        j   = 0;
        idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= NCH) j = j - NCH;
            if (pend[j]) idx = CHW'(j);
        end
    end

    assign any = |pend;

endmodule

// File: rtl/adc_conv_sched.sv
// SAR ADC conversion scheduler: round-robin grant, settle, start, done/timeout, tagged response.
//
// state     | meaning
// ST_IDLE   | waiting for en and a pending request
// ST_SETTLE | input mux switched, counting down settle_cycles
// ST_START  | one-cycle adc_start pulse, timer cleared
// ST_CONV   | waiting for a done rising edge or the timeout
// ST_RESP   | one-cycle response strobe, served pending bit cleared
module adc_conv_sched
    import adc_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int TMO = TMO_DEF
) (
    input logic              clk,
    input logic              rst,
    adc_conv_sched_if.master bus
);
    localparam int CHW = $clog2(NCH);
    localparam int TW  = $clog2(TMO + 1);

    sched_state_t     state, state_nxt;
    logic [NCH-1:0]   pend, pend_clr;
    logic [CHW-1:0]   rr_ptr, grant_idx, ch_q;
    logic             any_pend, grant, tmo_hit, done_q, done_rise;
    logic             cmp_sel_q, err_q;
    logic [7:0]       cnt;
    logic [TW-1:0]    timer;
    logic [ADC_W-1:0] data_q;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .pend   (pend),
        .rr_ptr (rr_ptr),
        .any    (any_pend),
        .idx    (grant_idx)
    );

    // A done level left high from a previous conversion must not complete this one.
    assign done_rise = bus.adc_done & ~done_q;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        tmo_hit   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.en && any_pend) begin
                    grant     = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: if (cnt == 8'd0) state_nxt = ST_START;
            ST_START:  state_nxt = ST_CONV;
            ST_CONV: begin
                if (done_rise) begin
                    state_nxt = ST_RESP;
                end else if (timer == TW'(TMO - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.adc_start = 1'b0;
        bus.adc_rst   = tmo_hit;
        bus.rsp_valid = 1'b0;
        bus.rsp_ch    = '0;
        bus.rsp_data  = '0;
        bus.rsp_err   = 1'b0;
        pend_clr      = '0;
        case (state)
            ST_START: bus.adc_start = 1'b1;
            ST_RESP: begin
                bus.rsp_valid  = 1'b1;
                bus.rsp_ch     = ch_q;
                bus.rsp_data   = data_q;
                bus.rsp_err    = err_q;
                pend_clr[ch_q] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            rr_ptr    <= '0;
            ch_q      <= '0;
            cmp_sel_q <= 1'b0;
            cnt       <= '0;
            timer     <= '0;
            done_q    <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            // A new request landing on the bit being cleared stays queued.
            pend   <= (pend & ~pend_clr) | bus.req;
            done_q <= bus.adc_done;
            if (grant) begin
                ch_q      <= grant_idx;
                cmp_sel_q <= bus.cfg_cmp_sel[grant_idx];
                cnt       <= bus.settle_cycles;
                rr_ptr    <= (grant_idx == CHW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state == ST_SETTLE && cnt != 8'd0) cnt <= cnt - 1'b1;
            if (state == ST_START) begin
                timer <= '0;
            end else if (state == ST_CONV && !done_rise && !tmo_hit) begin
                timer <= timer + 1'b1;
            end
            if (state == ST_CONV && done_rise) begin
                data_q <= bus.adc_data;
                err_q  <= 1'b0;
            end else if (tmo_hit) begin
                data_q <= '0;
                err_q  <= 1'b1;
            end
        end
    end

    assign bus.mux_sel     = ch_q;
    assign bus.adc_cmp_sel = cmp_sel_q;
    assign bus.pending     = pend;
    assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_adc_conv_sched.sv
// Directed scenarios plus randomized request batches checked against a transaction-level model.
module tb_adc_conv_sched;
    localparam int NCH = 4;
    localparam int CHW = 2;

    typedef struct {
        logic [7:0]     data;
        logic           err;
        logic [CHW-1:0] ch;
        logic           cmp;
    } adc_ev_t;

    logic clk, rst;
    int   total, bad;

    logic       auto_adc, allow_tmo;
    logic       auto_done, man_done;
    logic [7:0] auto_data, man_data;
    adc_ev_t    adc_q[$];

    adc_conv_sched_if #(.NCH(NCH)) bus ();

    adc_conv_sched #(.NCH(NCH), .TMO(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.adc_done = auto_adc ? auto_done : man_done;
    assign bus.adc_data = auto_adc ? auto_data : man_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ADC macro stand-in: answers each start after a random delay, or never (timeout).
    initial begin : adc_model
        int         cd;
        logic [7:0] nd;
        adc_ev_t    ev;
        cd        = -1;
        nd        = '0;
        auto_done = 1'b0;
        auto_data = '0;
        forever begin
            tick();
            if (!auto_adc) begin
                cd        = -1;
                auto_done = 1'b0;
            end else begin
                auto_done = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        auto_done = 1'b1;
                        auto_data = nd;
                        cd        = -1;
                    end
                end
                if (bus.adc_start === 1'b1) begin
                    ev.ch  = bus.mux_sel;
                    ev.cmp = bus.adc_cmp_sel;
                    if (allow_tmo && $urandom_range(0, 5) == 0) begin
                        ev.data = '0;
                        ev.err  = 1'b1;
                        cd      = -1;
                    end else begin
                        nd      = 8'($urandom);
                        ev.data = nd;
                        ev.err  = 1'b0;
                        cd      = int'($urandom_range(1, 12));
                    end
                    adc_q.push_back(ev);
                end
            end
        end
    end

    task automatic do_reset();
        rst                = 1'b1;
        auto_adc           = 1'b0;
        allow_tmo          = 1'b0;
        man_done           = 1'b0;
        man_data           = '0;
        bus.req            = '0;
        bus.en             = 1'b1;
        bus.cfg_cmp_sel    = '0;
        bus.settle_cycles  = '0;
        tick();
        tick();
        rst = 1'b0;
        adc_q.delete();
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (bus.adc_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (bus.rsp_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst     = 1'b1;
        bus.req = 4'b1111;
        tick();
        tick();
        total++;
        if (bus.pending !== 4'b0000 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state pending=%b busy=%b want 0000/0", bus.pending, bus.busy);
        end
        total++;
        if (bus.mux_sel !== 2'd0 || bus.adc_cmp_sel !== 1'b0 || bus.adc_start !== 1'b0 || bus.adc_rst !== 1'b0) begin
            bad++;
            $display("FAIL reset_adc mux=%0d cmp=%b start=%b arst=%b want all 0",
                     bus.mux_sel, bus.adc_cmp_sel, bus.adc_start, bus.adc_rst);
        end
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_ch !== 2'd0 || bus.rsp_data !== 8'h00 || bus.rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_rsp v=%b ch=%0d d=%h e=%b want all 0",
                     bus.rsp_valid, bus.rsp_ch, bus.rsp_data, bus.rsp_err);
        end
        bus.req = '0;
        rst     = 1'b0;
    endtask

    task automatic test_single();
        int n;
        bit ok;
        do_reset();
        bus.settle_cycles = 8'd3;
        bus.req = 4'b0100;
        tick();
        bus.req = '0;
        total++;
        if (bus.pending !== 4'b0100 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL single_pend pending=%b busy=%b want 0100/0", bus.pending, bus.busy);
        end
        tick();
        total++;
        if (bus.busy !== 1'b1 || bus.mux_sel !== 2'd2) begin
            bad++;
            $display("FAIL single_grant busy=%b mux=%0d want 1/2", bus.busy, bus.mux_sel);
        end
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            n++;
            if (bus.adc_start === 1'b1) ok = 1'b1;
        end
        total++;
        if (!ok || n != 4) begin
            bad++;
            $display("FAIL single_start_lat got=%0d seen=%b want 4", n, ok);
        end
        repeat (9) tick();
        man_data = 8'hA5;
        man_done = 1'b1;
        tick();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_ch !== 2'd2 || bus.rsp_data !== 8'hA5 || bus.rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL single_rsp v=%b ch=%0d d=%h e=%b want 1/2/a5/0",
                     bus.rsp_valid, bus.rsp_ch, bus.rsp_data, bus.rsp_err);
        end
        man_done = 1'b0;
        tick();
        total++;
        if (bus.pending !== 4'b0000 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_after pending=%b busy=%b v=%b want 0000/0/0",
                     bus.pending, bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [CHW-1:0] exp_ch[5];
        adc_ev_t        e;
        bit             ok;
        exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        auto_adc          = 1'b1;
        bus.settle_cycles = 8'd1;
        bus.req = 4'b1111;
        tick();
        bus.req = '0;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL rr_timeout idx=%0d got no rsp_valid want rsp", k);
                break;
            end
            total++;
            if (bus.rsp_ch !== exp_ch[k]) begin
                bad++;
                $display("FAIL rr_order idx=%0d got=%0d want=%0d", k, bus.rsp_ch, exp_ch[k]);
            end
            total++;
            if (adc_q.size() == 0) begin
                bad++;
                $display("FAIL rr_data idx=%0d got no adc start recorded want one", k);
            end else begin
                e = adc_q.pop_front();
                if (bus.rsp_data !== e.data || bus.rsp_err !== e.err) begin
                    bad++;
                    $display("FAIL rr_data idx=%0d got=%h/%b want=%h/%b",
                             k, bus.rsp_data, bus.rsp_err, e.data, e.err);
                end
            end
            if (k == 0) begin
                bus.req = 4'b0001;
                tick();
                bus.req = '0;
                total++;
                if (bus.pending !== 4'b1111) begin
                    bad++;
                    $display("FAIL rr_requeue pending=%b want 1111", bus.pending);
                end
            end
        end
        auto_adc = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        do_reset();
        bus.req = 4'b0010;
        tick();
        bus.req = '0;
        wait_start(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL tmo_start got no adc_start want one");
            return;
        end
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            n++;
            if (bus.adc_rst === 1'b1) ok = 1'b1;
        end
        total++;
        if (!ok || n != 64 || bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL tmo_rst_lat got=%0d seen=%b v=%b want 64/1/0", n, ok, bus.rsp_valid);
        end
        tick();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 8'h00 ||
            bus.rsp_ch !== 2'd1 || bus.adc_rst !== 1'b0) begin
            bad++;
            $display("FAIL tmo_rsp v=%b e=%b d=%h ch=%0d arst=%b want 1/1/00/1/0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_ch, bus.adc_rst);
        end
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.pending !== 4'b0000) begin
            bad++;
            $display("FAIL tmo_idle busy=%b pending=%b want 0/0000", bus.busy, bus.pending);
        end
    endtask

    task automatic test_stale_done();
        bit ok, seen;
        do_reset();
        bus.settle_cycles = 8'd2;
        bus.req = 4'b1000;
        tick();
        bus.req = '0;
        tick();
        man_done = 1'b1;
        man_data = 8'h11;
        wait_start(ok);
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (!ok || seen) begin
            bad++;
            $display("FAIL stale_done start=%b rsp_seen=%b want 1/0", ok, seen);
        end
        man_done = 1'b0;
        tick();
        man_done = 1'b1;
        man_data = 8'h3C;
        tick();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h3C || bus.rsp_ch !== 2'd3 || bus.rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL stale_rsp v=%b d=%h ch=%0d e=%b want 1/3c/3/0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_ch, bus.rsp_err);
        end
        man_done = 1'b0;
    endtask

    task automatic test_reset_mid_conv();
        bit ok, seen;
        do_reset();
        bus.settle_cycles = 8'd1;
        bus.req = 4'b0101;
        tick();
        bus.req = '0;
        wait_start(ok);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        total++;
        if (!ok || bus.busy !== 1'b0 || bus.pending !== 4'b0000 || bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_conv start=%b busy=%b pending=%b v=%b want 1/0/0000/0",
                     ok, bus.busy, bus.pending, bus.rsp_valid);
        end
        rst      = 1'b0;
        man_done = 1'b1;
        seen     = 1'b0;
        repeat (6) begin
            tick();
            if (bus.rsp_valid === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL rst_aborted got activity after reset want none");
        end
        man_done = 1'b0;
    endtask

    task automatic test_enable_cfg();
        int n;
        bit ok, granted;
        do_reset();
        bus.en            = 1'b0;
        bus.cfg_cmp_sel   = 4'b0010;
        bus.settle_cycles = 8'd0;
        bus.req = 4'b1010;
        tick();
        bus.req = '0;
        granted = 1'b0;
        repeat (10) begin
            tick();
            if (bus.busy !== 1'b0) granted = 1'b1;
        end
        total++;
        if (granted || bus.pending !== 4'b1010) begin
            bad++;
            $display("FAIL en_hold granted=%b pending=%b want 0/1010", granted, bus.pending);
        end
        bus.en = 1'b1;
        tick();
        total++;
        if (bus.busy !== 1'b1 || bus.mux_sel !== 2'd1 || bus.adc_cmp_sel !== 1'b1) begin
            bad++;
            $display("FAIL en_grant busy=%b mux=%0d cmp=%b want 1/1/1", bus.busy, bus.mux_sel, bus.adc_cmp_sel);
        end
        bus.cfg_cmp_sel   = 4'b0000;
        bus.settle_cycles = 8'd9;
        tick();
        total++;
        if (bus.adc_start !== 1'b1) begin
            bad++;
            $display("FAIL settle0_start got=%b want 1", bus.adc_start);
        end
        tick();
        total++;
        if (bus.adc_cmp_sel !== 1'b1 || bus.mux_sel !== 2'd1) begin
            bad++;
            $display("FAIL cfg_hold cmp=%b mux=%0d want 1/1", bus.adc_cmp_sel, bus.mux_sel);
        end
        man_data = 8'h77;
        man_done = 1'b1;
        tick();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_ch !== 2'd1 || bus.rsp_data !== 8'h77) begin
            bad++;
            $display("FAIL en_rsp v=%b ch=%0d d=%h want 1/1/77", bus.rsp_valid, bus.rsp_ch, bus.rsp_data);
        end
        man_done = 1'b0;
        tick();
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle busy=%b want 0", bus.busy);
        end
        tick();
        total++;
        if (bus.busy !== 1'b1 || bus.mux_sel !== 2'd3 || bus.adc_cmp_sel !== 1'b0) begin
            bad++;
            $display("FAIL b2b_grant busy=%b mux=%0d cmp=%b want 1/3/0", bus.busy, bus.mux_sel, bus.adc_cmp_sel);
        end
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            n++;
            if (bus.adc_start === 1'b1) ok = 1'b1;
        end
        total++;
        if (!ok || n != 10) begin
            bad++;
            $display("FAIL settle9_lat got=%0d seen=%b want 10", n, ok);
        end
    endtask

    task automatic test_random();
        int             rr, c;
        int             exp_q[$];
        logic [NCH-1:0] mask, cfg;
        adc_ev_t        e;
        bit             ok;
        do_reset();
        auto_adc  = 1'b1;
        allow_tmo = 1'b1;
        rr        = 0;
        for (int b = 0; b < 12; b++) begin
            mask = NCH'($urandom_range(1, (1 << NCH) - 1));
            cfg  = NCH'($urandom);
            bus.cfg_cmp_sel   = cfg;
            bus.settle_cycles = 8'($urandom_range(0, 4));
            bus.req = mask;
            tick();
            bus.req = '0;
            exp_q.delete();
            for (int k = 0; k < NCH; k++) begin
                c = (rr + k) % NCH;
                if (mask[c]) exp_q.push_back(c);
            end
            while (exp_q.size() > 0) begin
                c = exp_q.pop_front();
                wait_rsp(ok);
                total++;
                if (!ok || adc_q.size() == 0) begin
                    bad++;
                    $display("FAIL rnd_timeout batch=%0d ch=%0d got rsp=%b starts=%0d want rsp", b, c, ok, adc_q.size());
                    return;
                end
                e = adc_q.pop_front();
                total++;
                if (bus.rsp_ch !== CHW'(c) || e.ch !== CHW'(c) || e.cmp !== cfg[c]) begin
                    bad++;
                    $display("FAIL rnd_chan batch=%0d got rsp_ch=%0d mux=%0d cmp=%b want ch=%0d cmp=%b",
                             b, bus.rsp_ch, e.ch, e.cmp, c, cfg[c]);
                end
                total++;
                if (bus.rsp_data !== e.data || bus.rsp_err !== e.err) begin
                    bad++;
                    $display("FAIL rnd_data batch=%0d ch=%0d got=%h/%b want=%h/%b",
                             b, c, bus.rsp_data, bus.rsp_err, e.data, e.err);
                end
                rr = (c + 1) % NCH;
            end
            tick();
            total++;
            if (bus.pending !== '0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL rnd_drain batch=%0d pending=%b busy=%b want 0/0", b, bus.pending, bus.busy);
            end
        end
        auto_adc = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_stale_done();
        test_reset_mid_conv();
        test_enable_cfg();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
